// File: rtl/benes_cfg_sequencer.sv
// benes_cfg_sequencer
// Control-plane sequencer for a pipelined Benes network. Holds NUM_SLOTS switch
// configurations, loads them one stage word per beat over a ready/valid stream,
// and steers every stage's switch_set from the slot of the job currently in
// that stage. A slot is only overwritten once no job using it is in flight.
// Optional build macro: BENES_SEQ_PERF_EN adds the perf_jobs / perf_stall
// saturating event counters.
module benes_cfg_sequencer #(
  parameter int SIZE        = 32,
  parameter int LAYER_NUM   = $clog2(SIZE),
  parameter int STAGE_NUM   = 2 * LAYER_NUM - 1,
  parameter int SWITCH_NUM  = SIZE / 2,
  parameter int NET_LATENCY = STAGE_NUM - 1,
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_W      = $clog2(NUM_SLOTS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [SLOT_W-1:0]                     cfg_slot,
  input  logic [SWITCH_NUM-1:0]                 cfg_data,
  output logic                                  cfg_done,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [SLOT_W-1:0]                     in_slot,
  output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]  switch_set,
  output logic                                  net_in_en,
  output logic                                  out_valid,
  output logic [SLOT_W-1:0]                     out_slot,
  output logic [NUM_SLOTS-1:0]                  slot_loaded
`ifdef BENES_SEQ_PERF_EN
  ,
  output logic [31:0]                           perf_jobs,
  output logic [31:0]                           perf_stall
`endif
);

  // The pipe must reach both the last switch stage and the output tap.
  localparam int PIPE_LEN = (STAGE_NUM > NET_LATENCY + 1) ? STAGE_NUM : NET_LATENCY + 1;
  localparam int BUSY_W   = $clog2(NET_LATENCY + 2);
  localparam int CNT_W    = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(STAGE_NUM - 1);

  typedef enum logic [1:0] {C_IDLE, C_LOAD, C_WAIT, C_COMMIT} cfg_state_e;
  typedef logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] slot_cfg_t;

  cfg_state_e           state_q, state_d;
  logic [SLOT_W-1:0]    target_q;
  logic [CNT_W-1:0]     cnt_q;
  slot_cfg_t            stage_buf_q;
  slot_cfg_t            cfg_mem_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_loaded_q;
  logic [PIPE_LEN-1:0]  vld_pipe_q;
  logic [SLOT_W-1:0]    tag_pipe_q [PIPE_LEN];
  logic [BUSY_W-1:0]    busy_q [NUM_SLOTS];

  logic                 accept_cfg, lock_target, commit;
  logic                 beat_fire, in_fire, target_busy;
  logic [NUM_SLOTS-1:0] busy_inc, busy_dec;

  // Config FSM state register.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= C_IDLE;
    else     state_q <= state_d;
  end

  // Config FSM next-state logic.
  // NOTE: the default at the top of a combinational block guarantees every
  // path assigns the signal, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      C_IDLE:   if (beat_fire) state_d = (STAGE_NUM == 1) ? C_WAIT : C_LOAD;
      C_LOAD:   if (beat_fire && cnt_q == LAST_BEAT) state_d = C_WAIT;
      C_WAIT:   if (!target_busy) state_d = C_COMMIT;
      C_COMMIT: state_d = C_IDLE;
      default:  state_d = C_IDLE;
    endcase
  end

  // Config FSM outputs: beat acceptance, target lock and commit strobe.
  always_comb begin
    accept_cfg  = 1'b0;
    lock_target = 1'b0;
    commit      = 1'b0;
    unique case (state_q)
      C_IDLE, C_LOAD: accept_cfg = 1'b1;
      C_WAIT:         lock_target = 1'b1;
      C_COMMIT: begin
        lock_target = 1'b1;
        commit      = 1'b1;
      end
      default: ;
    endcase
  end

  // cfg_ready is held low while reset is asserted even though the FSM idles.
  assign cfg_ready   = accept_cfg & ~rst;
  assign cfg_done    = commit;
  assign beat_fire   = cfg_valid & cfg_ready;
  assign target_busy = (busy_q[target_q] != '0);

  // A job to an unloaded slot, or to the slot being swapped, simply waits.
  assign in_ready = slot_loaded_q[in_slot] & ~(lock_target & (target_q == in_slot));
  assign in_fire  = in_valid & in_ready;

  // Collect incoming stage words; the slot index is taken from the first beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q    <= '0;
      cnt_q       <= '0;
      stage_buf_q <= '0;
    end else if (beat_fire) begin
      if (state_q == C_IDLE) begin
        target_q       <= cfg_slot;
        stage_buf_q[0] <= cfg_data;
        cnt_q          <= CNT_W'(1);
      end else begin
        stage_buf_q[cnt_q] <= cfg_data;
        cnt_q              <= cnt_q + 1'b1;
      end
    end
  end

  // Copy the staged configuration into its slot in a single cycle.
  // NOTE: the configuration store is a small flop array, so it is cleared on
  // reset; a RAM-backed store would not be, and slot_loaded would guard it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) cfg_mem_q[i] <= '0;
      slot_loaded_q <= '0;
    end else if (commit) begin
      cfg_mem_q[target_q]     <= stage_buf_q;
      slot_loaded_q[target_q] <= 1'b1;
    end
  end

  // Valid/tag pipes that follow each job's data through the network stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      for (int s = 0; s < PIPE_LEN; s++) tag_pipe_q[s] <= '0;
    end else begin
      vld_pipe_q[0] <= in_fire;
      tag_pipe_q[0] <= in_fire ? in_slot : '0;
      for (int s = 1; s < PIPE_LEN; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        tag_pipe_q[s] <= tag_pipe_q[s-1];
      end
    end
  end

  // Per-slot in-flight increment/decrement events.
  always_comb begin
    busy_inc = '0;
    busy_dec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      busy_inc[i] = in_fire & (in_slot == SLOT_W'(i));
      busy_dec[i] = out_valid & (out_slot == SLOT_W'(i));
    end
  end

  // Per-slot in-flight counters; simultaneous issue and retire cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) busy_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (busy_inc[i] && !busy_dec[i])      busy_q[i] <= busy_q[i] + 1'b1;
        else if (!busy_inc[i] && busy_dec[i]) busy_q[i] <= busy_q[i] - 1'b1;
      end
    end
  end

  // Each stage takes its word from the slot of the job currently in it.
  always_comb begin
    switch_set = '0;
    for (int s = 0; s < STAGE_NUM; s++) begin
      if (vld_pipe_q[s]) switch_set[s] = cfg_mem_q[tag_pipe_q[s]][s];
    end
  end

  assign net_in_en   = vld_pipe_q[0];
  assign out_valid   = vld_pipe_q[NET_LATENCY];
  assign out_slot    = tag_pipe_q[NET_LATENCY];
  assign slot_loaded = slot_loaded_q;

`ifdef BENES_SEQ_PERF_EN
  logic [31:0] perf_jobs_q, perf_stall_q;

  // Saturating counters of accepted jobs and stalled job requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_jobs_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (in_fire && perf_jobs_q != '1)                  perf_jobs_q  <= perf_jobs_q + 1'b1;
      if (in_valid && !in_ready && perf_stall_q != '1)   perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_jobs  = perf_jobs_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// Testbench for benes_cfg_sequencer (default build, 32-port network).
// Inputs change 1 time unit after the rising edge; outputs are recorded per
// cycle on the falling edge into log arrays and compared against expectations
// computed here from the stage words the bench itself loads.
module tb_benes_cfg_sequencer;

  localparam int STAGE_NUM  = 9;
  localparam int SWITCH_NUM = 16;
  localparam int NUM_SLOTS  = 4;
  localparam int SLOT_W     = 2;
  localparam int NET_LAT    = 8;
  localparam int LOG_N      = 1024;

  typedef logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] cfg_t;
  typedef struct {
    logic [SLOT_W-1:0] slot;
    logic              exp_ready;
  } rdy_vec_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cfg_valid = 1'b0;
  logic                  cfg_ready;
  logic [SLOT_W-1:0]     cfg_slot = '0;
  logic [SWITCH_NUM-1:0] cfg_data = '0;
  logic                  cfg_done;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [SLOT_W-1:0]     in_slot = '0;
  cfg_t                  switch_set;
  logic                  net_in_en;
  logic                  out_valid;
  logic [SLOT_W-1:0]     out_slot;
  logic [NUM_SLOTS-1:0]  slot_loaded;

  benes_cfg_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_slot    (cfg_slot),
    .cfg_data    (cfg_data),
    .cfg_done    (cfg_done),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_slot     (in_slot),
    .switch_set  (switch_set),
    .net_in_en   (net_in_en),
    .out_valid   (out_valid),
    .out_slot    (out_slot),
    .slot_loaded (slot_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cfg_t              log_sw     [LOG_N];
  logic              log_ov     [LOG_N];
  logic [SLOT_W-1:0] log_os     [LOG_N];
  logic              log_en     [LOG_N];
  logic              log_done   [LOG_N];
  logic              log_fire   [LOG_N];
  logic              log_cready [LOG_N];

  always @(negedge clk) begin
    if (cyc < LOG_N) begin
      log_sw[cyc]     <= switch_set;
      log_ov[cyc]     <= out_valid;
      log_os[cyc]     <= out_slot;
      log_en[cyc]     <= net_in_en;
      log_done[cyc]   <= cfg_done;
      log_fire[cyc]   <= in_valid & in_ready;
      log_cready[cyc] <= cfg_ready;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_ov(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (log_ov[k] !== 1'b0) n++;
    return n;
  endfunction

  function automatic int count_en(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (log_en[k] !== 1'b0) n++;
    return n;
  endfunction

  // Mismatching stages for a job whose data enters stage 0 in cycle t0.
  function automatic int job_mismatch(input int t0, input cfg_t exp);
    int n = 0;
    for (int s = 0; s < STAGE_NUM; s++) if (log_sw[t0+s][s] !== exp[s]) n++;
    return n;
  endfunction

  // Streams nbeats stage words into a slot; with a full load it also waits
  // for cfg_done and returns the cycle in which it was seen.
  task automatic load_slot(input logic [SLOT_W-1:0] slot, input cfg_t beats, input int nbeats,
                           output int first, output int done_cyc);
    int g;
    first    = -1;
    done_cyc = -1;
    for (int b = 0; b < nbeats; b++) begin
      cfg_valid = 1'b1;
      cfg_slot  = slot;
      cfg_data  = beats[b];
      g = 0;
      while (!cfg_ready && g < 200) begin tick(); g++; end
      if (g == 200) check("cfg_ready wait", cfg_ready, 1);
      if (b == 0) first = cyc;
      tick();
    end
    cfg_valid = 1'b0;
    if (nbeats == STAGE_NUM) begin
      g = 0;
      while (!cfg_done && g < 200) begin tick(); g++; end
      if (g == 200) check("cfg_done wait", cfg_done, 1);
      done_cyc = cyc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cfg_t     b0, b1, b2, b0n;
    rdy_vec_t vt [4];
    int       t, ts, tn, first, dc, rc, nf, lst;

    // Stage words: b0[0] is the first beat (16'h00FF).
    b0 = {16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h6996,
          16'h6996, 16'h3CC3, 16'h0FF0, 16'h00FF};
    b1 = '1;
    for (int s = 0; s < STAGE_NUM; s++) begin
      b2[s]  = 16'h2200 + 16'(s);
      b0n[s] = 16'hA000 + 16'(s);
    end

    vt[0] = '{slot: 2'd0, exp_ready: 1'b1};
    vt[1] = '{slot: 2'd1, exp_ready: 1'b1};
    vt[2] = '{slot: 2'd2, exp_ready: 1'b0};
    vt[3] = '{slot: 2'd3, exp_ready: 1'b0};

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst cfg_ready",   cfg_ready, 0);
    check("rst in_ready",    in_ready, 0);
    check("rst out_valid",   out_valid, 0);
    check("rst net_in_en",   net_in_en, 0);
    check("rst switch_set",  switch_set, 0);
    check("rst slot_loaded", slot_loaded, 0);
    check("rst cfg_done",    cfg_done, 0);
    rst = 1'b0;
    #1;
    check("post-rst cfg_ready", cfg_ready, 1);
    tick();

    // ---------------- load slot 0 ----------------
    // Beats in cycles first..first+8, C_WAIT at +9, C_COMMIT (cfg_done) at +10:
    // the 11th cycle of the load counting the first beat.
    load_slot(2'd0, b0, STAGE_NUM, first, dc);
    check("load0 cfg_done latency", dc - first, 10);
    tick();
    check("load0 slot_loaded", slot_loaded, 4'b0001);
    check("load0 cfg_done one-shot", cfg_done, 0);

    // ---------------- single job to slot 0 ----------------
    in_valid = 1'b1;
    in_slot  = 2'd0;
    #1;
    check("single in_ready", in_ready, 1);
    t = cyc;
    tick();
    in_valid = 1'b0;
    repeat (12) tick();
    check("single net_in_en t",   log_en[t], 0);
    check("single net_in_en t+1", log_en[t+1], 1);
    check("single net_in_en t+2", log_en[t+2], 0);
    for (int s = 0; s < STAGE_NUM; s++) begin
      check($sformatf("single sw[%0d] before", s), log_sw[t+s][s], 0);
      check($sformatf("single sw[%0d] active", s), log_sw[t+1+s][s], b0[s]);
      check($sformatf("single sw[%0d] after", s),  log_sw[t+2+s][s], 0);
    end
    check("single out_valid t+8", log_ov[t+8], 0);
    check("single out_valid t+9", log_ov[t+9], 1);
    check("single out_slot t+9",  log_os[t+9], 0);
    check("single out_valid t+10", log_ov[t+10], 0);

    // ---------------- load slot 1, ready table ----------------
    load_slot(2'd1, b1, STAGE_NUM, first, dc);
    tick();
    check("load1 slot_loaded", slot_loaded, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      in_slot = vt[i].slot;
      #1;
      check($sformatf("in_ready table slot %0d", vt[i].slot), in_ready, vt[i].exp_ready);
    end
    tick();

    // ---------------- alternating jobs 0,1,0,1 ----------------
    in_valid = 1'b1;
    t = cyc;
    for (int j = 0; j < 4; j++) begin
      in_slot = 2'(j % 2);
      tick();
    end
    in_valid = 1'b0;
    repeat (14) tick();
    for (int j = 0; j < 4; j++) begin
      check($sformatf("alt fire %0d", j), log_fire[t+j], 1);
      for (int s = 0; s < STAGE_NUM; s++)
        check($sformatf("alt job%0d sw[%0d]", j, s), log_sw[t+1+j+s][s], (j % 2) ? b1[s] : b0[s]);
      check($sformatf("alt out_valid %0d", j), log_ov[t+9+j], 1);
      check($sformatf("alt out_slot %0d", j),  log_os[t+9+j], 2'(j % 2));
    end

    // ---------------- stall on unloaded slot 2 ----------------
    in_valid = 1'b1;
    in_slot  = 2'd2;
    t = cyc;
    repeat (20) tick();
    nf = 0;
    for (int k = t; k < t + 20; k++) if (log_fire[k] !== 1'b0) nf++;
    check("stall no fire", nf, 0);
    check("stall in_ready", in_ready, 0);
    load_slot(2'd2, b2, STAGE_NUM, first, dc);
    check("stall in_ready during commit", in_ready, 0);
    tick();
    check("stall in_ready after done", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (12) tick();
    check("stall fire at cfg_done", log_fire[dc], 0);
    check("stall fire after cfg_done", log_fire[dc+1], 1);
    check("stall no early out_valid", count_ov(t, dc + 9), 0);
    check("stall out_valid", log_ov[dc+10], 1);
    check("stall out_slot",  log_os[dc+10], 2);
    check("stall job stages", job_mismatch(dc + 2, b2), 0);

    // ---------------- reload slot 0 with 3 jobs in flight ----------------
    // Beats at ts..ts+8; slot-0 jobs fire at ts+6..ts+8 and retire at
    // ts+15..ts+17, so the FSM sits in C_WAIT from ts+9 until they are gone.
    ts = cyc;
    fork
      load_slot(2'd0, b0n, STAGE_NUM, first, dc);
      begin
        repeat (6) tick();
        in_valid = 1'b1;
        in_slot  = 2'd0;
        repeat (3) tick();
        in_valid = 1'b0;
      end
    join
    in_valid = 1'b1;
    in_slot  = 2'd0;
    tick();
    check("reload new job in_ready", in_ready, 1);
    tn = cyc;
    tick();
    in_valid = 1'b0;
    repeat (12) tick();
    check("reload first beat", first - ts, 0);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("reload fire %0d", j), log_fire[ts+6+j], 1);
      check($sformatf("reload out_valid %0d", j), log_ov[ts+15+j], 1);
      check($sformatf("reload out_slot %0d", j), log_os[ts+15+j], 0);
      check($sformatf("reload old contents job %0d", j), job_mismatch(ts + 7 + j, b0), 0);
    end
    lst = ts + 17;
    check("reload commit after last out", (dc >= lst + 1) && (dc <= lst + 2), 1);
    nf = 0;
    for (int k = ts + 9; k <= dc; k++) if (log_cready[k] !== 1'b0) nf++;
    check("reload cfg_ready low while waiting", nf, 0);
    check("reload no fire while locked", log_fire[dc], 0);
    check("reload new job fire", log_fire[tn], 1);
    check("reload new contents", job_mismatch(tn + 1, b0n), 0);
    check("reload new job out_valid", log_ov[tn+9], 1);

    // ---------------- reset mid-load with 2 jobs in flight ----------------
    in_valid = 1'b1;
    in_slot  = 2'd1;
    repeat (2) tick();
    in_valid = 1'b0;
    load_slot(2'd3, b2, 4, first, dc);
    cfg_valid = 1'b1;
    cfg_slot  = 2'd3;
    cfg_data  = b2[4];
    in_slot   = 2'd1;
    #1;
    rst = 1'b1;
    #1;
    check("midrst cfg_ready",   cfg_ready, 0);
    check("midrst in_ready",    in_ready, 0);
    check("midrst out_valid",   out_valid, 0);
    check("midrst out_slot",    out_slot, 0);
    check("midrst net_in_en",   net_in_en, 0);
    check("midrst switch_set",  switch_set, 0);
    check("midrst slot_loaded", slot_loaded, 0);
    check("midrst cfg_done",    cfg_done, 0);
    cfg_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("midrst cfg_ready after release", cfg_ready, 1);
    rc = cyc;
    repeat (15) tick();
    check("midrst no out_valid", count_ov(rc, rc + 14), 0);
    check("midrst no net_in_en", count_en(rc, rc + 14), 0);
    check("midrst slot_loaded stays 0", slot_loaded, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
